// File: rtl/stream_arb_mux.sv
// stream_arb_mux
// N-channel valid/ready stream multiplexer with internal arbitration.
// MODE 0 = round-robin, MODE 1 = fixed priority (lowest index wins).
// A channel that wins keeps the output until its last beat is accepted.
// The output stream is held in a single register slot.
module stream_arb_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int MODE       = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH-1:0]            in_last,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         out_ready
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Arbiter state
  state_t          state_r;
  state_t          state_n_s;
  logic [CH_W-1:0] gnt_r;
  logic [CH_W-1:0] gnt_n_s;
  logic [CH_W-1:0] ptr_r;
  logic [CH_W-1:0] ptr_n_s;

  // Winner search
  logic [CH_W-1:0] start_s;
  logic [CH_W:0]   sum_s;
  logic [CH_W-1:0] idx_s;
  logic [CH_W-1:0] win_s;
  logic            win_found_s;

  // Current grant and handshake
  logic [CH_W-1:0]       cur_s;
  logic                  cur_active_s;
  logic                  cur_valid_s;
  logic                  cur_last_s;
  logic [DATA_WIDTH-1:0] cur_data_s;
  logic [CH_W-1:0]       ptr_inc_s;
  logic                  space_s;
  logic                  xfer_s;

  // Output register slot
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic [CH_W-1:0]       out_ch_r;

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_ch    = out_ch_r;

  // The slot can accept a word if it is empty or being drained this cycle.
  assign space_s = ~out_valid_r | out_ready;

  // Find the first valid channel, scanning upward from ptr (round-robin) or from 0 (priority).
  always_comb begin
    win_s       = '0;
    win_found_s = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    start_s     = (MODE == 0) ? ptr_r : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum_s = {1'b0, start_s} + (CH_W+1)'(i);
      if (sum_s >= (CH_W+1)'(NUM_CH)) begin
        idx_s = CH_W'(sum_s - (CH_W+1)'(NUM_CH));
      end else begin
        idx_s = CH_W'(sum_s);
      end
      if (!win_found_s && in_valid[idx_s]) begin
        win_found_s = 1'b1;
        win_s       = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // While locked the held grant owns the output; otherwise the fresh winner does.
  assign cur_s        = (state_r == ST_LOCKED) ? gnt_r : win_s;
  assign cur_active_s = (state_r == ST_LOCKED) | win_found_s;

  // Route the granted channel's valid, last and data onto the shared path.
  always_comb begin
    cur_valid_s = 1'b0;
    cur_last_s  = 1'b0;
    cur_data_s  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_s == CH_W'(k)) begin
        cur_valid_s = in_valid[k];
        cur_last_s  = in_last[k];
        cur_data_s  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        cur_valid_s = cur_valid_s;
      end
    end
  end

  assign xfer_s    = space_s & cur_active_s & cur_valid_s;
  assign ptr_inc_s = (cur_s == CH_W'(NUM_CH - 1)) ? '0 : cur_s + CH_W'(1);

  // Raise ready only on the granted channel, and never while reset is asserted.
  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rst && space_s && cur_active_s && (cur_s == CH_W'(k))) begin
        in_ready[k] = 1'b1;
      end else begin
        in_ready[k] = 1'b0;
      end
    end
  end

  // Next-state logic: lock on a non-last beat, release on the owner's last beat.
  always_comb begin
    state_n_s = state_r;
    gnt_n_s   = gnt_r;
    ptr_n_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s && !cur_last_s) begin
          state_n_s = ST_LOCKED;
          gnt_n_s   = cur_s;
        end else if (xfer_s && cur_last_s) begin
          state_n_s = ST_IDLE;
          ptr_n_s   = (MODE == 0) ? ptr_inc_s : ptr_r;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s && cur_last_s) begin
          state_n_s = ST_IDLE;
          ptr_n_s   = (MODE == 0) ? ptr_inc_s : ptr_r;
        end else begin
          state_n_s = ST_LOCKED;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        gnt_n_s   = '0;
        ptr_n_s   = '0;
      end
    endcase
  end

  // Arbiter state register; reset discards any packet in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      ptr_r   <= '0;
    end else begin
      state_r <= state_n_s;
      gnt_r   <= gnt_n_s;
      ptr_r   <= ptr_n_s;
    end
  end

  // Output slot: load on input transfer, clear valid on drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_ch_r    <= '0;
    end else if (xfer_s) begin
      out_data_r  <= cur_data_s;
      out_valid_r <= 1'b1;
      out_last_r  <= cur_last_s;
      out_ch_r    <= cur_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule
